// File: rtl/oct_scan_driver.sv
// Purpose : time-multiplexed scan driver for a 3-digit octal readout of an 8-bit value.
// Latency : LOAD reaches the display at the next frame boundary (1 cycle best, 3*SCAN_DIV worst).
// Backpres: none; LOAD is never refused, and the newest shadowed value overwrites older ones.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   load, value      one-cycle capture strobe and the 8-bit value to show
//   dig              octal digit for the current slot (bit 0 -> decoder A0)
//   dig_en           active-low digit enables, bit 0 = least-significant digit
//   blank            current slot suppressed by leading-zero blanking
//   frame            one-cycle pulse on the first cycle of slot 0
//   pending          shadow holds a value not yet displayed
//
// Build option: define OCT_LZB_EN to enable leading-zero blanking of slots 1 and 2.

module oct_scan_driver #(
   parameter int SCAN_DIV  = 50000,
   parameter int GUARD_CYC = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] value,
   output logic [2:0] dig,
   output logic [2:0] dig_en,
   output logic       blank,
   output logic       frame,
   output logic       pending
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } slot_t;

   slot_t         slot;
   logic [PW-1:0] presc;
   logic [7:0]    shadow;
   logic [7:0]    active;

   logic          last_cyc;
   logic          boundary;
   logic [PW-1:0] nxt_presc;
   slot_t         nxt_slot;
   logic [7:0]    nxt_active;
   logic [2:0]    nxt_dig;
   logic [2:0]    nxt_pat;
   logic          nxt_blank;

   // Next-state values; outputs are registered from these so that they line
   // up with the prescaler/slot registers in the same cycle.
   always_comb begin
      last_cyc   = (presc == PW'(SCAN_DIV - 1));
      boundary   = last_cyc && (slot == S2);
      nxt_presc  = last_cyc ? '0 : presc + 1'b1;
      nxt_slot   = slot;
      if (last_cyc) begin
         case (slot)
            S0:      nxt_slot = S1;
            S1:      nxt_slot = S2;
            default: nxt_slot = S0;
         endcase
      end

      // A LOAD on the boundary itself bypasses the shadow so it is not
      // delayed by a whole extra frame.
      nxt_active = active;
      if (boundary) begin
         if (load)         nxt_active = value;
         else if (pending) nxt_active = shadow;
      end

      case (nxt_slot)
         S1: begin
            nxt_dig = nxt_active[5:3];
            nxt_pat = 3'b101;
         end
         S2: begin
            nxt_dig = {1'b0, nxt_active[7:6]};
            nxt_pat = 3'b011;
         end
         default: begin
            nxt_dig = nxt_active[2:0];
            nxt_pat = 3'b110;
         end
      endcase

`ifdef OCT_LZB_EN
      // Slot 0 is never blanked so a zero value still shows a single "0".
      case (nxt_slot)
         S1:      nxt_blank = (nxt_active[7:3] == 5'd0);
         S2:      nxt_blank = (nxt_active[7:6] == 2'd0);
         default: nxt_blank = 1'b0;
      endcase
`else
      nxt_blank = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot    <= S0;
         presc   <= '0;
         shadow  <= 8'd0;
         active  <= 8'd0;
         pending <= 1'b0;
         dig     <= 3'd0;
         dig_en  <= 3'b111;
         blank   <= 1'b0;
         frame   <= 1'b0;
      end else begin
         slot   <= nxt_slot;
         presc  <= nxt_presc;
         active <= nxt_active;

         if (boundary) begin
            pending <= 1'b0;
            if (load) shadow <= value;
         end else if (load) begin
            shadow  <= value;
            pending <= 1'b1;
         end

         // active only changes at the S2->S0 edge, so the digit is stable
         // for the whole slot even though it is recomputed every cycle.
         dig    <= nxt_dig;
         blank  <= nxt_blank;
         dig_en <= ((nxt_presc < PW'(GUARD_CYC)) || nxt_blank) ? 3'b111 : nxt_pat;
         frame  <= boundary;
      end
   end

endmodule

// File: tb/tb_oct_scan_driver.sv
module tb_oct_scan_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic [7:0] value;
   logic [2:0] dig;
   logic [2:0] dig_en;
   logic       blank;
   logic       frame;
   logic       pending;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   oct_scan_driver #(.SCAN_DIV(8), .GUARD_CYC(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .value   (value),
      .dig     (dig),
      .dig_en  (dig_en),
      .blank   (blank),
      .frame   (frame),
      .pending (pending)
   );

   always #5 clk = ~clk;

   // Cycle index since reset release: slot = (cyc/8)%3, prescaler = cyc%8.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [2:0] exp_dig(input logic [7:0] v, input int s);
      if (s == 0)      return v[2:0];
      else if (s == 1) return v[5:3];
      else             return {1'b0, v[7:6]};
   endfunction

   function automatic logic exp_blank(input logic [7:0] v, input int s);
`ifdef OCT_LZB_EN
      if (s == 2)      return (v[7:6] == 2'd0);
      else if (s == 1) return (v[7:3] == 5'd0);
      else             return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [2:0] exp_en(input logic [7:0] v, input int s, input int p);
      if (p < 2 || exp_blank(v, s)) return 3'b111;
      if (s == 0)      return 3'b110;
      else if (s == 1) return 3'b101;
      else             return 3'b011;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_to(input int r);
      int n = 0;
      while ((cyc % 24) != r && n < 100) begin
         step();
         n++;
      end
      total++;
      if ((cyc % 24) != r) begin
         bad++;
         $display("FAIL wait_to: phase=%0d required=%0d", cyc % 24, r);
      end
   endtask

   // Entered at a frame start; checks every cycle of one frame.
   task automatic check_frame(input logic [7:0] v, input logic f0, input string nm);
      for (int i = 0; i < 24; i++) begin
         int s = i / 8;
         int p = i % 8;
         total++;
         if (dig !== exp_dig(v, s)) begin
            bad++;
            $display("FAIL %s dig i=%0d: got=%0d exp=%0d", nm, i, dig, exp_dig(v, s));
         end
         total++;
         if (dig_en !== exp_en(v, s, p)) begin
            bad++;
            $display("FAIL %s dig_en i=%0d: got=%b exp=%b", nm, i, dig_en, exp_en(v, s, p));
         end
         total++;
         if (blank !== exp_blank(v, s)) begin
            bad++;
            $display("FAIL %s blank i=%0d: got=%b exp=%b", nm, i, blank, exp_blank(v, s));
         end
         total++;
         if (frame !== ((i == 0) ? f0 : 1'b0)) begin
            bad++;
            $display("FAIL %s frame i=%0d: got=%b exp=%b", nm, i, frame, (i == 0) ? f0 : 1'b0);
         end
         step();
      end
   endtask

   task automatic check_reset_outs(input string nm);
      total++;
      if ({dig, dig_en, blank, frame, pending} !== {3'd0, 3'b111, 1'b0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL %s: got dig=%0d en=%b blank=%b frame=%b pend=%b exp dig=0 en=111 blank=0 frame=0 pend=0",
                  nm, dig, dig_en, blank, frame, pending);
      end
   endtask

   task automatic do_load(input logic [7:0] v);
      load  = 1'b1;
      value = v;
      step();
      load  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      value = 8'd0;
      step();
      step();
      check_reset_outs("reset_state");
      rst_n = 1'b1;
   endtask

   task automatic test_scan();
      check_frame(8'h00, 1'b0, "scan_first");
      check_frame(8'h00, 1'b1, "scan_second");
      check_frame(8'h00, 1'b1, "scan_third");
   endtask

   task automatic test_load_pending();
      wait_to(12);
      do_load(8'hFF);
      while ((cyc % 24) != 0) begin
         total++;
         if (pending !== 1'b1) begin
            bad++;
            $display("FAIL pend_hold phase=%0d: got=%b exp=1", cyc % 24, pending);
         end
         step();
      end
      total++;
      if (pending !== 1'b0) begin
         bad++;
         $display("FAIL pend_clear: got=%b exp=0", pending);
      end
      check_frame(8'hFF, 1'b1, "show_377");
   endtask

   task automatic test_two_loads();
      wait_to(3);
      do_load(8'h05);
      wait_to(10);
      do_load(8'h2A);
      wait_to(0);
      total++;
      if (pending !== 1'b0) begin
         bad++;
         $display("FAIL two_pend: got=%b exp=0", pending);
      end
      check_frame(8'h2A, 1'b1, "show_052");
   endtask

   task automatic test_bypass();
      wait_to(23);
      total++;
      if (pending !== 1'b0) begin
         bad++;
         $display("FAIL bypass_pre: got=%b exp=0", pending);
      end
      do_load(8'h40);
      total++;
      if (pending !== 1'b0) begin
         bad++;
         $display("FAIL bypass_pend: got=%b exp=0", pending);
      end
      check_frame(8'h40, 1'b1, "bypass_100");
   endtask

   task automatic test_blanking();
      wait_to(5);
      do_load(8'h07);
      wait_to(0);
      check_frame(8'h07, 1'b1, "blank_007");
      wait_to(5);
      do_load(8'h00);
      wait_to(0);
      check_frame(8'h00, 1'b1, "blank_000");
   endtask

   task automatic test_reset_mid();
      wait_to(5);
      do_load(8'hFF);
      wait_to(0);
      check_frame(8'hFF, 1'b1, "pre_rst_377");
      wait_to(6);
      do_load(8'h55);
      wait_to(19);
      total++;
      if (pending !== 1'b1 || dig !== 3'd3) begin
         bad++;
         $display("FAIL rst_pre: got pend=%b dig=%0d exp pend=1 dig=3", pending, dig);
      end
      #2 rst_n = 1'b0;
      #1 check_reset_outs("rst_async");
      step();
      step();
      check_reset_outs("rst_hold");
      rst_n = 1'b1;
      check_frame(8'h00, 1'b0, "post_rst_first");
      total++;
      if (pending !== 1'b0) begin
         bad++;
         $display("FAIL post_rst_pend: got=%b exp=0", pending);
      end
      check_frame(8'h00, 1'b1, "post_rst_second");
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load_pending();
      test_two_loads();
      test_bypass();
      test_blanking();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/oct_scan_driver.md
# oct_scan_driver

Time-multiplexed scan driver for the three-digit octal readout of the 8-bit RPN ALU result. It captures an 8-bit value and splits it into three octal digits. It then presents one 3-bit digit per scan slot to the octal seven-segment decoder (A0..A2) while driving the matching active-low digit enable. New values are double-buffered and applied only at frame boundaries, so a digit never tears mid-scan.

## Interface
- SCAN_DIV, 50000, clock cycles per digit slot; must be ≥ 4.
- GUARD_CYC, 16, cycles at the start of each slot with all enables off (anti-ghosting); must satisfy 1 ≤ GUARD_CYC < SCAN_DIV.

- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- LOAD  in  1  one-cycle strobe; captures VALUE.
- VALUE  in  8  unsigned ALU result.
- DIG  out  3  current octal digit, bit 0 → decoder A0, bit 2 → A2.
- DIG_EN  out  3  active-low digit enables; bit 0 = least-significant digit.
- BLANK  out  1  high while the current slot is suppressed by leading-zero blanking.
- FRAME  out  1  one-cycle pulse on the first cycle of slot 0.
- PENDING  out  1  shadow register holds a value not yet displayed.

All outputs are registered.

## Operation
- Registers:
  - shadow[7:0]
  - active[7:0]
  - slot ∈ {S0, S1, S2}
  - prescaler counter 0..SCAN_DIV-1
- Digit split of active:
  - d0 = active[2:0]
  - d1 = active[5:3]
  - d2 = {1'b0, active[7:6]}
  - Maximum display is 377.
- State machine:
  - S0 → S1 → S2 → S0.
  - A transition occurs when the prescaler reaches SCAN_DIV-1; the prescaler then wraps to 0.
- Within a slot:
  - Prescaler < GUARD_CYC: DIG_EN = 3'b111.
  - Otherwise, DIG_EN drives the slot's bit low: S0 → 3'b110, S1 → 3'b101, S2 → 3'b011.
  - DIG updates to the slot's digit on the first cycle of the slot and holds for the whole slot.
- LOAD when not at a frame boundary: shadow ← VALUE, PENDING ← 1. A further LOAD while PENDING overwrites shadow; the last value wins.
- Frame boundary is the cycle in which S2 wraps to S0. On that edge:
  - If PENDING: active ← shadow, PENDING ← 0.
  - If LOAD is asserted on the same cycle: active ← VALUE directly (bypass), shadow ← VALUE, PENDING ← 0.
- FRAME is asserted for exactly the first cycle of every S0.

## Timing
- Reset (RST_N low, asynchronous):
  - Registers: shadow = active = 0, slot = S0, prescaler = 0.
  - Outputs: DIG = 0, DIG_EN = 3'b111, BLANK = 0, FRAME = 0, PENDING = 0.
- First cycle after reset release:
  - Slot S0 begins with prescaler = 0.
  - FRAME is not asserted for this partial start; the first FRAME occurs after one full frame.
- Slot length is SCAN_DIV cycles; frame length is 3·SCAN_DIV cycles.
- LOAD-to-display latency: worst case 3·SCAN_DIV cycles, best case 1 cycle (boundary bypass).
- PENDING rises the cycle after LOAD and falls on the frame-boundary edge.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately.
  - Any pending value is discarded.

## Configuration
- OCT_LZB_EN defined (leading-zero blanking):
  - Slot S2 is blanked when d2 = 0.
  - Slot S1 is blanked when d2 = 0 and d1 = 0.
  - S0 is never blanked, so a value of 0 shows "0".
  - In a blanked slot, DIG_EN stays 3'b111 for the whole slot and BLANK = 1; DIG still carries the digit.
- OCT_LZB_EN undefined:
  - All three slots are always enabled after their guard interval.
  - BLANK is constant 0.

## Test plan
Parameters for all scenarios: SCAN_DIV = 8, GUARD_CYC = 2.
- Reset release, no LOAD: DIG = 0 in every slot; the DIG_EN pattern repeats 111,111,110×6; 111,111,101×6; 111,111,011×6; FRAME pulses every 24 cycles starting at cycle 24.
- LOAD VALUE = 8'hFF mid-S1: PENDING = 1 until the next S2→S0 edge. Then DIG sequence per frame is 7, 7, 3 (displays 377), and PENDING = 0.
- Two LOADs in one frame, 8'h05 then 8'h2A: the next frame shows 2, 5, 0 (octal 052); 8'h05 is never displayed.
- LOAD 8'h40 on the exact S2→S0 boundary cycle: active = 8'h40 from the next cycle, PENDING stays 0, and that frame shows 0, 0, 1.
- With OCT_LZB_EN, VALUE = 8'h07: S1 and S2 have DIG_EN = 111 and BLANK = 1; S0 shows 7. With VALUE = 8'h00, only S0 is lit, showing 0.
- RST_N pulsed low mid-S2 with PENDING = 1: outputs drop to reset values asynchronously. After release the display shows 0 and PENDING = 0.
